// File: rtl/nanoz80_uart_pkg.sv
// rtl/nanoz80_uart_pkg.sv - shared types, constants and helpers for the nano-z80 UART
package nanoz80_uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int cpb(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/nanoz80_uart_rx_if.sv
// rtl/nanoz80_uart_rx_if.sv - serial line and CPU-side port bundle of the UART receiver
interface nanoz80_uart_rx_if;

  logic       uart_rx_i;
  logic       rd_i;
  logic       clr_err_i;
  logic [7:0] data_o;
  logic       rx_avail_o;
  logic       rx_full_o;
  logic       overrun_o;
  logic       frame_err_o;

  modport master (
    output uart_rx_i, rd_i, clr_err_i,
    input  data_o, rx_avail_o, rx_full_o, overrun_o, frame_err_o
  );

  modport slave (
    input  uart_rx_i, rd_i, clr_err_i,
    output data_o, rx_avail_o, rx_full_o, overrun_o, frame_err_o
  );

endinterface

// File: rtl/nanoz80_sync_fifo.sv
// rtl/nanoz80_sync_fifo.sv - first-word-fall-through FIFO with extra-MSB full/empty pointers
module nanoz80_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
  assign w_do_pop  = pop_i && !w_empty;
  assign w_do_push = push_i && (!w_full || w_do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data_i;
  end

  assign data_o     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign empty_o    = w_empty;
  assign full_o     = w_full;
  assign overflow_o = push_i && !w_do_push;

endmodule

// File: rtl/nanoz80_uart_rx.sv
// rtl/nanoz80_uart_rx.sv - 8N1 receiver with FIFO; NANOZ80_UART_RX_MAJORITY_EN enables 3-sample voting
module nanoz80_uart_rx
  import nanoz80_uart_pkg::*;
#(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  nanoz80_uart_rx_if.slave   bus
);

  localparam int CPB = cpb(CLK_HZ, BAUD);
  localparam int CW  = $clog2(CPB) + 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CPB - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic          r_sync1;
  logic          r_sync2;
  rx_state_t     r_state;
  rx_state_t     w_state_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_overrun;
  logic          r_frame_err;

  logic w_tick;
  logic w_act;
  logic w_bit;
  logic w_load_half;
  logic w_idx_clr;
  logic w_shift;
  logic w_push;
  logic w_frame_err_set;
  logic w_fifo_empty;
  logic w_fifo_full;
  logic w_fifo_ovf;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.uart_rx_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_cnt == '0) && (r_state inside {START, DATA, STOP});

`ifdef NANOZ80_UART_RX_MAJORITY_EN
  logic r_prev;
  logic r_s_m1;
  logic r_s_0;
  logic r_pend;

  // Votes over tick-1, tick, tick+1; the FSM acts one cycle after the tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prev <= 1'b1;
      r_s_m1 <= 1'b1;
      r_s_0  <= 1'b1;
      r_pend <= 1'b0;
    end else begin
      r_prev <= r_sync2;
      r_pend <= w_tick;
      if (w_tick) begin
        r_s_m1 <= r_prev;
        r_s_0  <= r_sync2;
      end
    end
  end

  assign w_act = r_pend;
  assign w_bit = (r_s_m1 & r_s_0) | (r_s_m1 & r_sync2) | (r_s_0 & r_sync2);
`else
  assign w_act = w_tick;
  assign w_bit = r_sync2;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    w_load_half     = 1'b0;
    w_idx_clr       = 1'b0;
    w_shift         = 1'b0;
    w_push          = 1'b0;
    w_frame_err_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_sync2) begin
          w_load_half  = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        if (w_act) begin
          if (!w_bit) begin
            w_idx_clr    = 1'b1;
            w_state_next = DATA;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (w_act) begin
          w_shift = 1'b1;
          if (r_bit_idx == LAST_BIT) w_state_next = STOP;
        end
      end
      STOP: begin
        if (w_act) begin
          if (w_bit) begin
            w_push       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_frame_err_set = 1'b1;
            w_state_next    = BREAK;
          end
        end
      end
      BREAK: begin
        if (r_sync2) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The timer reloads on every tick so the next mid-bit point stays one bit period away.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (w_load_half)     r_cnt <= HALF_LOAD;
      else if (w_tick)     r_cnt <= FULL_LOAD;
      else if (r_cnt != 0) r_cnt <= r_cnt - CW'(1);

      if (w_idx_clr)    r_bit_idx <= '0;
      else if (w_shift) r_bit_idx <= r_bit_idx + 3'd1;

      if (w_shift) r_shift <= {w_bit, r_shift[7:1]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_fifo_ovf)         r_overrun <= 1'b1;
      else if (bus.clr_err_i) r_overrun <= 1'b0;

      if (w_frame_err_set)    r_frame_err <= 1'b1;
      else if (bus.clr_err_i) r_frame_err <= 1'b0;
    end
  end

  nanoz80_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .push_data_i (r_shift),
    .pop_i       (bus.rd_i),
    .data_o      (bus.data_o),
    .empty_o     (w_fifo_empty),
    .full_o      (w_fifo_full),
    .overflow_o  (w_fifo_ovf)
  );

  assign bus.rx_avail_o  = !w_fifo_empty;
  assign bus.rx_full_o   = w_fifo_full;
  assign bus.overrun_o   = r_overrun;
  assign bus.frame_err_o = r_frame_err;

endmodule

// File: doc/nanoz80_uart_rx.md
Name: nanoz80_uart_rx

Overview:
- UART receiver for the nano-z80 serial console. Sits directly downstream of the top-level uart_rx_i pin and feeds received bytes to the Z80 I/O port decoder.
- Synchronises the asynchronous line and deserialises 8N1 frames at a fixed baud rate.
- Buffers bytes in a small FIFO so that CPU polling latency does not drop characters.

Parameters:
- CLK_HZ, 27000000, system clock frequency in Hz.
- BAUD, 115200, line rate. CPB = CLK_HZ/BAUD (integer floor; default 234), required >= 8.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, >= 2.

Ports:
- clk_i  in  1  system clock (single clock domain).
- rst_i  in  1  reset, asynchronous, active-high.
- uart_rx_i  in  1  serial line, idle high, asynchronous to clk_i.
- rd_i  in  1  pop strobe from the CPU I/O read of the data port; one pop per high cycle.
- data_o  out  8  head-of-FIFO byte (first-word-fall-through); 0 when empty.
- rx_avail_o  out  1  FIFO non-empty.
- rx_full_o  out  1  FIFO full.
- overrun_o  out  1  sticky; a byte was dropped because the FIFO was full.
- frame_err_o  out  1  sticky; the stop bit was sampled low.
- clr_err_i  in  1  clears both sticky flags.

Behaviour:
- Reset (async assert, clk-synchronous release):
  - All outputs 0. FIFO empty, pointers 0.
  - Synchroniser flops reset to 1 (line idle). FSM goes to IDLE.
  - Reset mid-frame aborts the frame and flushes the FIFO.
- Synchroniser: 2 flops; rxs is the second flop. Line-to-rxs latency is 2 cycles.
- Bit timer: counter loaded per state; a "tick" fires when it reaches 0.
- FSM states:
  - IDLE: rxs==0 -> load CPB/2-1, go to START.
  - START: on tick, rxs==0 -> load CPB-1, bit index 0, go to DATA. rxs==1 -> glitch, go to IDLE with no flag.
  - DATA: on tick, shift rxs into the shift register LSB-first and reload CPB-1. After the 8th bit go to STOP.
  - STOP, on tick with rxs==1: push the byte and go to IDLE.
  - STOP, on tick with rxs==0: set frame_err, discard the byte, go to BREAK.
  - BREAK: stay until rxs==1, then go to IDLE. Prevents a break condition from producing 0x00 bytes.
- Push timing: rx_avail_o and data_o update on the cycle after the stop-bit tick.
- FIFO:
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits wide. Empty when the pointers are equal; full when only the MSBs differ.
  - rd_i while empty is ignored; pointers are unchanged.
  - Push while full: byte dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle while full: both succeed, no overrun.
  - Push and pop in the same cycle while empty: only the push takes effect.
- Sticky flags: clr_err_i clears both. A set in the same cycle as clr_err_i wins.
- Back-to-back frames: IDLE re-arms on the same cycle the stop bit is accepted, so a start edge half a bit later is caught.

Optional Feature:
- Macro NANOZ80_UART_RX_MAJORITY_EN.
- Defined: each start, data and stop sample is the 2-of-3 majority of rxs at tick-1, tick and tick+1. The decision is taken one cycle after the tick, so push latency grows by 1 cycle. Requires CPB >= 8.
- Undefined: single sample of rxs at the tick.

Decomposition:
- Package nanoz80_uart_pkg holds:
  - rx_state_t enum {IDLE, START, DATA, STOP, BREAK}.
  - Function cpb(clk_hz, baud).
  - Localparam for the data-bit count (8).
- Sub-module nanoz80_sync_fifo: parameterised width/depth, FWFT, full/empty, simultaneous push/pop rules as specified above. Reusable by the future TX path.

Test Plan:
- All scenarios use CLK_HZ=1600000, BAUD=100000 (CPB=16).
- Single byte: send 0x55 as 8N1 -> rx_avail_o rises 1 cycle after the stop tick. data_o==0x55. After one rd_i pulse, rx_avail_o==0.
- Glitch: drive uart_rx_i low for 4 cycles -> no byte, no flags, FSM back in IDLE.
- Framing/break: send 0xA3 with stop bit 0, then hold the line low for 40 bit times -> frame_err_o=1, FIFO empty, no 0x00 bytes. Releasing the line then sending 0x41 -> 0x41 received. clr_err_i clears frame_err_o.
- Overrun: send 17 bytes 0x00..0x10 without reads -> rx_full_o=1, overrun_o=1. Reads return 0x00..0x0F in order; 0x10 is lost.
- Full with simultaneous pop: FIFO full, rd_i asserted in the push cycle of byte 0x77 -> no overrun; 0x77 is the last of 16 entries.
- Reset mid-frame: assert rst_i during bit 4 of 0xC3 with 3 bytes queued -> outputs 0 immediately (async). After release, the next frame 0x12 is received cleanly.
